// File: rtl/game_classic_status_if.sv
// Bundles the classic-mode control inputs and display-facing outputs of game_classic_status.
// The master side drives the game controls; the slave side is the timer/score engine.
interface game_classic_status_if;
  logic        enable_game_classic;
  logic        pause;
  logic        hit;
  logic        miss;
  logic [15:0] led_classic;
  logic [15:0] seg_classic;
  logic [4:0]  score_classic;
  logic        game_over;

  modport master (
    output enable_game_classic, pause, hit, miss,
    input  led_classic, seg_classic, score_classic, game_over
  );

  modport slave (
    input  enable_game_classic, pause, hit, miss,
    output led_classic, seg_classic, score_classic, game_over
  );
endinterface

// File: rtl/game_classic_status.sv
// Classic-mode timer/score engine: LED-bar countdown, BCD remaining seconds and saturating score.
// Define GAME_CLASSIC_MISS_PENALTY_EN to make a miss cost one LED step of time.
module game_classic_status #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int SEC_PER_LED = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  game_classic_status_if.slave bus
);

  localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [2:0]      SUB_MAX = 3'(SEC_PER_LED - 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t        r_state, w_stateNext;
  logic [4:0]    r_ledCnt, w_ledNext;
  logic [2:0]    r_subSec, w_subNext;
  logic [4:0]    r_score, w_scoreNext;
  logic [PW-1:0] r_prescaler, w_preNext;
  logic [15:0]   r_seg, w_segNext;
  logic          w_active;
  logic          w_tick;
  logic          w_ledStep;
  logic          w_missDec;
  logic [1:0]    w_dec;
  logic [6:0]    w_remSec;

  assign w_active  = (r_state == RUN) && bus.enable_game_classic && !bus.pause;
  assign w_tick    = w_active && (r_prescaler == PRE_MAX);
  assign w_ledStep = w_tick && (r_subSec == 3'd0);

`ifdef GAME_CLASSIC_MISS_PENALTY_EN
  assign w_missDec = w_active && bus.miss;
`else
  logic w_unusedMiss;
  assign w_unusedMiss = bus.miss;
  assign w_missDec    = 1'b0;
`endif

  // A tick step and a miss penalty can land together, so the LED count may drop by two.
  assign w_dec = {1'b0, w_ledStep} + {1'b0, w_missDec};

  always_comb begin
    w_stateNext = r_state;
    w_ledNext   = r_ledCnt;
    w_subNext   = r_subSec;
    w_scoreNext = r_score;
    w_preNext   = r_prescaler;
    case (r_state)
      IDLE: begin
        if (bus.enable_game_classic) begin
          w_stateNext = RUN;
          w_ledNext   = 5'd16;
          w_subNext   = SUB_MAX;
          w_scoreNext = 5'd0;
          w_preNext   = '0;
        end
      end
      RUN: begin
        if (!bus.enable_game_classic) begin
          w_stateNext = IDLE;
          w_ledNext   = 5'd0;
          w_subNext   = 3'd0;
          w_scoreNext = 5'd0;
          w_preNext   = '0;
        end else begin
          if (!bus.pause) begin
            w_preNext = (r_prescaler == PRE_MAX) ? '0 : r_prescaler + PW'(1);
          end
          if (w_tick) begin
            w_subNext = (r_subSec == 3'd0) ? SUB_MAX : r_subSec - 3'd1;
          end
          w_ledNext = (r_ledCnt > 5'(w_dec)) ? r_ledCnt - 5'(w_dec) : 5'd0;
          if (bus.hit && !bus.pause && (r_score != 5'd31)) begin
            w_scoreNext = r_score + 5'd1;
          end
          if (w_ledNext == 5'd0) begin
            w_stateNext = OVER;
          end
        end
      end
      OVER: begin
        if (!bus.enable_game_classic) begin
          w_stateNext = IDLE;
          w_ledNext   = 5'd0;
          w_subNext   = 3'd0;
          w_scoreNext = 5'd0;
          w_preNext   = '0;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Display digits are built from the already-registered counters, hence one cycle behind them.
  always_comb begin
    w_remSec = 7'd0;
    if (r_ledCnt != 5'd0) begin
      w_remSec = 7'((int'(r_ledCnt) - 1) * SEC_PER_LED + int'(r_subSec) + 1);
    end
    w_segNext = '0;
    if (w_stateNext != IDLE) begin
      w_segNext = {4'(w_remSec / 7'd10), 4'(w_remSec % 7'd10),
                   4'(r_score / 5'd10), 4'(r_score % 5'd10)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ledCnt    <= 5'd0;
      r_subSec    <= 3'd0;
      r_score     <= 5'd0;
      r_prescaler <= '0;
      r_seg       <= 16'd0;
    end else begin
      r_state     <= w_stateNext;
      r_ledCnt    <= w_ledNext;
      r_subSec    <= w_subNext;
      r_score     <= w_scoreNext;
      r_prescaler <= w_preNext;
      r_seg       <= w_segNext;
    end
  end

  assign bus.led_classic   = {11'd0, r_ledCnt};
  assign bus.seg_classic   = r_seg;
  assign bus.score_classic = r_score;
  assign bus.game_over     = (r_state == OVER);

endmodule
